// File: rtl/hoop_pkg.sv
// hoop_pkg: constants and types shared by the hoop score controller and the hoop renderer.
//   - Rim, backboard and pole geometry in screen pixels. The renderer reads the same values,
//     so the drawn rim and the scoring window always agree.
//   - 12-bit {R,G,B} colour constants.
//   - Controller state enum.
//   - Helpers: an inclusive range test and a two-digit BCD increment.
package hoop_pkg;

    // Rim: the scoring window is [RimXL, RimXR]. RimY is the top of the rim.
    localparam logic [9:0] RimXL   = 10'd610;
    localparam logic [9:0] RimXR   = 10'd630;
    localparam logic [9:0] RimY    = 10'd155;

    // Backboard sits just right of the rim. The pole runs from the board down to the floor.
    localparam logic [9:0] BoardXL = 10'd631;
    localparam logic [9:0] BoardXR = 10'd637;
    localparam logic [9:0] BoardYT = 10'd95;
    localparam logic [9:0] BoardYB = 10'd170;
    localparam logic [9:0] PoleXL  = 10'd634;
    localparam logic [9:0] PoleXR  = 10'd639;
    localparam logic [9:0] PoleYT  = 10'd170;
    localparam logic [9:0] PoleYB  = 10'd479;

    localparam logic [11:0] RED   = 12'hF00;
    localparam logic [11:0] GREEN = 12'h0F0;
    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] GRAY  = 12'h888;
    localparam logic [11:0] BLACK = 12'h000;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StScore,
        StFlash
    } hoop_state_e;

    function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                     input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Add one to {tens, ones}. 99 wraps to 00.
    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = v[3:0];
        tens = v[7:4];
        if (ones >= 4'd9) begin
            ones = 4'd0;
            tens = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/hoop_score_ctrl_if.sv
// hoop_score_ctrl_if: connects the ball physics side to the score controller.
//   Physics/test side (master) drives:   frame_tick, ball_valid, ball_x, ball_y, score_clr
//   Controller (slave) drives:           hoop_rgb, score_bcd, score_pulse, flashing
interface hoop_score_ctrl_if;

    logic        frame_tick;
    logic        ball_valid;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic        score_clr;
    logic [11:0] hoop_rgb;
    logic [7:0]  score_bcd;
    logic        score_pulse;
    logic        flashing;

    modport master (
        output frame_tick,
        output ball_valid,
        output ball_x,
        output ball_y,
        output score_clr,
        input  hoop_rgb,
        input  score_bcd,
        input  score_pulse,
        input  flashing
    );

    modport slave (
        input  frame_tick,
        input  ball_valid,
        input  ball_x,
        input  ball_y,
        input  score_clr,
        output hoop_rgb,
        output score_bcd,
        output score_pulse,
        output flashing
    );

endinterface

// File: rtl/bcd_counter2.sv
// bcd_counter2: two-digit BCD counter, 00..99, wrapping from 99 to 00.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, clears the count to 00
//   clr    in   synchronous clear; takes priority over inc
//   inc    in   increment by one
//   bcd    out  {tens, ones}, registered
module bcd_counter2
    import hoop_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] bcd
);

    logic [7:0] bcd_q;
    logic [7:0] bcd_d;

    always_comb begin
        bcd_d = bcd_q;
        if (clr) begin
            bcd_d = 8'h00;
        end else if (inc) begin
            bcd_d = bcd_inc2(bcd_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= 8'h00;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/hoop_score_ctrl.sv
// hoop_score_ctrl: per-frame make detector and rim-flash controller for the hoop renderer.
// The ball position is sampled on each frame_tick. A make is a ball that was seen above the
// rim plane inside the rim x-span and is then seen at or below the plane, still inside it.
// A make bumps the BCD score, pulses score_pulse, and flashes the rim for FLASH_FRAMES frames.
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   bus.frame_tick    in   one-cycle pulse per frame
//   bus.ball_valid    in   ball in flight (level)
//   bus.ball_x/y      in   ball centre, 10 bits each
//   bus.score_clr     in   synchronous score clear
//   bus.hoop_rgb      out  rim colour {R,G,B}
//   bus.score_bcd     out  {tens, ones}
//   bus.score_pulse   out  one-cycle pulse per make
//   bus.flashing      out  high while the rim flashes
// Build option HOOP_BLINK_EN: the flash alternates FLASH_COLOR/RIM_COLOR every BLINK_PERIOD
// frames instead of holding FLASH_COLOR.
module hoop_score_ctrl
    import hoop_pkg::*;
#(
    parameter logic [9:0]  RIM_X_L      = RimXL,
    parameter logic [9:0]  RIM_X_R      = RimXR,
    parameter logic [9:0]  RIM_Y        = RimY,
    parameter int unsigned FLASH_FRAMES = 30,
    parameter int unsigned BLINK_PERIOD = 4,
    parameter logic [11:0] RIM_COLOR    = RED,
    parameter logic [11:0] FLASH_COLOR  = GREEN
) (
    input  logic               clk,
    input  logic               rst_n,
    hoop_score_ctrl_if.slave   bus
);

    if (FLASH_FRAMES < 1 || FLASH_FRAMES > 255 || BLINK_PERIOD < 1 || BLINK_PERIOD > 256)
    begin : g_bad_params
        $error("hoop_score_ctrl: FLASH_FRAMES must be 1..255, BLINK_PERIOD 1..256");
    end

    localparam logic [7:0] FlashLoad = 8'(FLASH_FRAMES);

    hoop_state_e state_q, state_d;
    logic [7:0]  flash_cnt_q, flash_cnt_d;
    logic [11:0] hoop_rgb_q, hoop_rgb_d;
    logic        pulse_q, pulse_d;
    logic        flashing_q, flashing_d;
    logic        make;
    logic        in_x;
    logic        above_rim;
    logic [7:0]  score_bcd;

`ifdef HOOP_BLINK_EN
    localparam logic [7:0] BlinkLast = 8'(BLINK_PERIOD - 1);

    // phase counts frame ticks within the current blink phase. blink_on is high in FLASH_COLOR phases.
    logic [7:0] phase_q, phase_d;
    logic       blink_on_q, blink_on_d;
`endif

    assign in_x      = in_span(bus.ball_x, RIM_X_L, RIM_X_R);
    assign above_rim = bus.ball_y < RIM_Y;

    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        hoop_rgb_d  = hoop_rgb_q;
        flashing_d  = flashing_q;
        pulse_d     = 1'b0;
        make        = 1'b0;
`ifdef HOOP_BLINK_EN
        phase_d     = phase_q;
        blink_on_d  = blink_on_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.frame_tick && bus.ball_valid && in_x && above_rim) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (bus.frame_tick) begin
                    if (!bus.ball_valid || !in_x) begin
                        state_d = StIdle;
                    end else if (!above_rim) begin
                        // Pulse and score both register on this edge, so they appear in SCORE.
                        state_d = StScore;
                        pulse_d = 1'b1;
                        make    = 1'b1;
                    end
                end
            end
            StScore: begin
                state_d     = StFlash;
                flash_cnt_d = FlashLoad;
                flashing_d  = 1'b1;
                hoop_rgb_d  = FLASH_COLOR;
`ifdef HOOP_BLINK_EN
                phase_d     = 8'd0;
                blink_on_d  = 1'b1;
`endif
            end
            StFlash: begin
                if (bus.frame_tick) begin
                    // A count of 0 cannot occur here. It is treated as the last frame so the FSM cannot stick.
                    if (flash_cnt_q <= 8'd1) begin
                        flash_cnt_d = 8'd0;
                        state_d     = StIdle;
                        flashing_d  = 1'b0;
                        hoop_rgb_d  = RIM_COLOR;
                    end else begin
                        flash_cnt_d = flash_cnt_q - 8'd1;
`ifdef HOOP_BLINK_EN
                        if (phase_q == BlinkLast) begin
                            phase_d    = 8'd0;
                            blink_on_d = !blink_on_q;
                            hoop_rgb_d = blink_on_q ? RIM_COLOR : FLASH_COLOR;
                        end else begin
                            phase_d = phase_q + 8'd1;
                        end
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            flash_cnt_q <= 8'd0;
            hoop_rgb_q  <= RIM_COLOR;
            pulse_q     <= 1'b0;
            flashing_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flash_cnt_q <= flash_cnt_d;
            hoop_rgb_q  <= hoop_rgb_d;
            pulse_q     <= pulse_d;
            flashing_q  <= flashing_d;
        end
    end

`ifdef HOOP_BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= 8'd0;
            blink_on_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            blink_on_q <= blink_on_d;
        end
    end
`endif

    bcd_counter2 u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.score_clr),
        .inc   (make),
        .bcd   (score_bcd)
    );

    assign bus.hoop_rgb    = hoop_rgb_q;
    assign bus.score_bcd   = score_bcd;
    assign bus.score_pulse = pulse_q;
    assign bus.flashing    = flashing_q;

endmodule

// File: tb/tb_hoop_score_ctrl.sv
module tb_hoop_score_ctrl;

    localparam int unsigned BP = 4;
`ifdef HOOP_BLINK_EN
    localparam int unsigned FF = 16;
`else
    localparam int unsigned FF = 30;
`endif
    localparam logic [11:0] RIM_C   = 12'hF00;
    localparam logic [11:0] FLASH_C = 12'h0F0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hoop_score_ctrl_if bus ();

    hoop_score_ctrl #(
        .FLASH_FRAMES (FF),
        .BLINK_PERIOD (BP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame-level reference model. It holds the armed flag, the remaining flash frames,
    // the frames since the flash started, and the score as a plain integer.
    bit m_armed;
    int m_flash_left;
    int m_k;
    int m_score;

    function automatic void model_reset();
        m_armed = 0;
        m_flash_left = 0;
        m_k = 0;
        m_score = 0;
    endfunction

    function automatic bit model_tick(input bit v, input int x, input int y, input bit clr);
        bit make;
        bit in_x;
        bit above;
        make  = 0;
        in_x  = (x >= 610) && (x <= 630);
        above = (y < 155);
        if (m_flash_left > 0) begin
            m_flash_left--;
            m_k++;
        end else if (m_armed && v && in_x && !above) begin
            make = 1;
            m_armed = 0;
            m_flash_left = FF;
            m_k = 0;
        end else begin
            m_armed = v && in_x && above;
        end
        if (make) m_score = (m_score + 1) % 100;
        if (clr) m_score = 0;
        return make;
    endfunction

    function automatic logic [11:0] model_rgb();
        if (m_flash_left == 0) return RIM_C;
`ifdef HOOP_BLINK_EN
        return (((m_k / BP) % 2) == 0) ? FLASH_C : RIM_C;
`else
        return FLASH_C;
`endif
    endfunction

    function automatic logic [7:0] to_bcd(input int s);
        return 8'(((s / 10) % 10) * 16 + (s % 10));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call this #1 after a rising edge. The task drives one tick cycle and returns #1 after
    // the edge that samples the tick.
    task automatic do_tick(input bit v, input int x, input int y, input bit clr, output bit make);
        bus.frame_tick = 1'b1;
        bus.ball_valid = v;
        bus.ball_x     = 10'(x);
        bus.ball_y     = 10'(y);
        bus.score_clr  = clr;
        make = model_tick(v, x, y, clr);
        step();
        bus.frame_tick = 1'b0;
        bus.score_clr  = 1'b0;
        bus.ball_valid = 1'b0;
    endtask

    // Run a whole flash. Every tick carries an arm/make ball pattern, which the flash must ignore.
    task automatic burn_flash(input bit verbose);
        bit mk;
        for (int i = 0; i < int'(FF); i++) begin
            do_tick(1'b1, 620, ((i % 2) == 0) ? 140 : 160, 1'b0, mk);
            if (verbose) check("flash_no_pulse", 32'(bus.score_pulse), 32'(0));
            step();
            if (verbose) begin
                check("flash_flashing", 32'(bus.flashing), 32'(i < int'(FF) - 1));
                check("flash_rgb", 32'(bus.hoop_rgb), 32'(model_rgb()));
            end
        end
    endtask

    task automatic make_shot();
        bit mk;
        do_tick(1'b1, 620, 140, 1'b0, mk);
        step();
        do_tick(1'b1, 620, 160, 1'b0, mk);
        step();
    endtask

    typedef struct {
        bit         v;
        int         x;
        int         y;
        bit         pulse;
        logic [7:0] score;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit mk;
        bus.frame_tick = 1'b0;
        bus.ball_valid = 1'b0;
        bus.ball_x     = '0;
        bus.ball_y     = '0;
        bus.score_clr  = 1'b0;
        model_reset();

        // Table of single ticks, starting from score 01 in IDLE. A pulse row expects the flash afterwards.
        vecs.push_back(vec_t'{1'b1, 620, 140, 1'b0, 8'h01}); // arm
        vecs.push_back(vec_t'{1'b1, 600, 160, 1'b0, 8'h01}); // wide miss
        vecs.push_back(vec_t'{1'b1, 620, 160, 1'b0, 8'h01}); // idle, below rim
        vecs.push_back(vec_t'{1'b1, 620, 155, 1'b0, 8'h01}); // y=155 does not arm
        vecs.push_back(vec_t'{1'b1, 620, 160, 1'b0, 8'h01});
        vecs.push_back(vec_t'{1'b1, 610, 154, 1'b0, 8'h01}); // left edge
        vecs.push_back(vec_t'{1'b1, 610, 155, 1'b1, 8'h02});
        vecs.push_back(vec_t'{1'b1, 630, 154, 1'b0, 8'h02}); // right edge
        vecs.push_back(vec_t'{1'b1, 630, 155, 1'b1, 8'h03});
        vecs.push_back(vec_t'{1'b1, 609, 154, 1'b0, 8'h03});
        vecs.push_back(vec_t'{1'b1, 609, 155, 1'b0, 8'h03});
        vecs.push_back(vec_t'{1'b1, 620, 155, 1'b0, 8'h03});
        vecs.push_back(vec_t'{1'b1, 631, 154, 1'b0, 8'h03});
        vecs.push_back(vec_t'{1'b1, 631, 155, 1'b0, 8'h03});
        vecs.push_back(vec_t'{1'b1, 620, 154, 1'b0, 8'h03}); // arm
        vecs.push_back(vec_t'{1'b1, 631, 155, 1'b0, 8'h03}); // drifts out
        vecs.push_back(vec_t'{1'b1, 620, 155, 1'b0, 8'h03});
        vecs.push_back(vec_t'{1'b1, 620, 100, 1'b0, 8'h03}); // arm
        vecs.push_back(vec_t'{1'b0, 620, 160, 1'b0, 8'h03}); // ball gone
        vecs.push_back(vec_t'{1'b1, 620, 160, 1'b0, 8'h03});
        vecs.push_back(vec_t'{1'b1, 620, 100, 1'b0, 8'h03}); // arm
        vecs.push_back(vec_t'{1'b1, 620, 120, 1'b0, 8'h03}); // stays armed
        vecs.push_back(vec_t'{1'b1, 625, 200, 1'b1, 8'h04});
        vecs.push_back(vec_t'{1'b1, 620, 140, 1'b0, 8'h04}); // arm
        vecs.push_back(vec_t'{1'b1, 640, 140, 1'b0, 8'h04}); // out of x above rim
        vecs.push_back(vec_t'{1'b1, 620, 160, 1'b0, 8'h04});

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", 32'(bus.hoop_rgb), 32'(RIM_C));
        check("rst_score", 32'(bus.score_bcd), 32'(8'h00));
        check("rst_pulse", 32'(bus.score_pulse), 32'(0));
        check("rst_flashing", 32'(bus.flashing), 32'(0));
        rst_n = 1'b1;
        step();

        // First make, with cycle-accurate latency
        do_tick(1'b1, 620, 140, 1'b0, mk);
        check("arm_no_pulse", 32'(bus.score_pulse), 32'(0));
        step();
        do_tick(1'b1, 620, 160, 1'b0, mk);
        check("make_pulse", 32'(bus.score_pulse), 32'(1));
        check("make_score", 32'(bus.score_bcd), 32'(8'h01));
        check("make_rgb_lat1", 32'(bus.hoop_rgb), 32'(RIM_C));
        check("make_flash_lat1", 32'(bus.flashing), 32'(0));
        step();
        check("make_pulse_end", 32'(bus.score_pulse), 32'(0));
        check("make_rgb_lat2", 32'(bus.hoop_rgb), 32'(FLASH_C));
        check("make_flash_lat2", 32'(bus.flashing), 32'(1));
        burn_flash(1'b1);
        check("after_flash_rgb", 32'(bus.hoop_rgb), 32'(RIM_C));

        // Table-driven boundary vectors
        foreach (vecs[i]) begin
            do_tick(vecs[i].v, vecs[i].x, vecs[i].y, 1'b0, mk);
            check($sformatf("vec%0d_pulse", i), 32'(bus.score_pulse), 32'(vecs[i].pulse));
            check($sformatf("vec%0d_score", i), 32'(bus.score_bcd), 32'(vecs[i].score));
            step();
            check($sformatf("vec%0d_flashing", i), 32'(bus.flashing), 32'(vecs[i].pulse));
            check($sformatf("vec%0d_rgb", i), 32'(bus.hoop_rgb),
                  32'(vecs[i].pulse ? FLASH_C : RIM_C));
            if (vecs[i].pulse) burn_flash(1'b0);
        end

        // score_clr during the SCORE cycle
        do_tick(1'b1, 620, 140, 1'b0, mk);
        step();
        do_tick(1'b1, 620, 160, 1'b0, mk);
        check("clr_score_pre", 32'(bus.score_bcd), 32'(8'h05));
        bus.score_clr = 1'b1;
        m_score = 0;
        step();
        bus.score_clr = 1'b0;
        check("clr_in_score", 32'(bus.score_bcd), 32'(8'h00));
        check("clr_keeps_flash", 32'(bus.flashing), 32'(1));
        burn_flash(1'b0);

        // score_clr on the same edge as the increment
        do_tick(1'b1, 620, 140, 1'b0, mk);
        step();
        do_tick(1'b1, 620, 160, 1'b1, mk);
        check("clr_vs_inc_pulse", 32'(bus.score_pulse), 32'(1));
        check("clr_vs_inc_score", 32'(bus.score_bcd), 32'(8'h00));
        step();
        burn_flash(1'b0);

        // Wrap: 99 makes, then one more
        for (int n = 0; n < 99; n++) begin
            make_shot();
            burn_flash(1'b0);
        end
        check("preload_99", 32'(bus.score_bcd), 32'(8'h99));
        do_tick(1'b1, 620, 140, 1'b0, mk);
        step();
        do_tick(1'b1, 620, 160, 1'b0, mk);
        check("wrap_pulse", 32'(bus.score_pulse), 32'(1));
        check("wrap_score", 32'(bus.score_bcd), 32'(8'h00));
        step();
        burn_flash(1'b0);

        // Asynchronous reset during a flash (score 03 going in)
        for (int n = 0; n < 3; n++) begin
            make_shot();
            burn_flash(1'b0);
        end
        make_shot();
        for (int n = 0; n < 10; n++) begin
            do_tick(1'b0, 0, 0, 1'b0, mk);
            step();
        end
        check("pre_rst_flashing", 32'(bus.flashing), 32'(1));
        check("pre_rst_score", 32'(bus.score_bcd), 32'(8'h04));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rgb", 32'(bus.hoop_rgb), 32'(RIM_C));
        check("mid_rst_score", 32'(bus.score_bcd), 32'(8'h00));
        check("mid_rst_flashing", 32'(bus.flashing), 32'(0));
        step();
        rst_n = 1'b1;
        model_reset();
        step();

        // Randomized ticks against the frame-level model
        for (int n = 0; n < 400; n++) begin
            bit v;
            bit clr;
            int x;
            int y;
            int gap;
            v   = ($urandom_range(9) != 0);
            x   = $urandom_range(640, 600);
            y   = $urandom_range(175, 135);
            clr = ($urandom_range(29) == 0);
            do_tick(v, x, y, clr, mk);
            check("rnd_pulse", 32'(bus.score_pulse), 32'(mk));
            check("rnd_score", 32'(bus.score_bcd), 32'(to_bcd(m_score)));
            step();
            check("rnd_pulse_end", 32'(bus.score_pulse), 32'(0));
            check("rnd_flashing", 32'(bus.flashing), 32'(m_flash_left > 0));
            check("rnd_rgb", 32'(bus.hoop_rgb), 32'(model_rgb()));
            gap = $urandom_range(3);
            for (int g = 0; g <= gap; g++) begin
                if (g == 0 && $urandom_range(39) == 0) begin
                    bus.score_clr = 1'b1;
                    m_score = 0;
                    step();
                    bus.score_clr = 1'b0;
                    check("rnd_gap_clr", 32'(bus.score_bcd), 32'(8'h00));
                end else begin
                    step();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
